// File: rtl/alu_bank_pipe_pkg.sv
// Shared types and constants for the banked ALU pipeline.
package alu_bank_pkg;

    localparam int DATA_W   = 16;
    localparam int FLAG_W   = 4;
    // Widest channel index the bank supports (NUM_ACC up to 16).
    localparam int CH_MAX_W = 4;

    localparam logic [1:0] MODE_EXEC  = 2'd0;
    localparam logic [1:0] MODE_LOAD  = 2'd1;
    localparam logic [1:0] MODE_READ  = 2'd2;
    localparam logic [1:0] MODE_CLEAR = 2'd3;

    // Bit positions inside a flag nibble.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Payload carried by every output stage.
    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [FLAG_W-1:0]   flags;
        logic [CH_MAX_W-1:0] ch;
    } result_t;

endpackage

// File: rtl/alu_bank_pipe_alu.sv
// Shared combinational ALU: 16-bit operation plus Z/N/C/V flags.
module alu_core
    import alu_bank_pkg::*;
(
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              carry_in,
    output logic [DATA_W-1:0] o,
    output logic [FLAG_W-1:0] flags
);

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_ADC = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;
    localparam logic [7:0] OP_SHL = 8'h06;
    localparam logic [7:0] OP_SHR = 8'h07;

    logic [DATA_W:0] sum;
    logic            c;
    logic            v;

    // Operation select; unknown opcodes produce zero with C/V cleared.
    always_comb begin
        sum = '0;
        o   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, x} + {1'b0, y};
                o   = sum[DATA_W-1:0];
                c   = sum[DATA_W];
                v   = (x[15] == y[15]) && (o[15] != x[15]);
            end
            OP_ADC: begin
                sum = {1'b0, x} + {1'b0, y} + {16'h0000, carry_in};
                o   = sum[DATA_W-1:0];
                c   = sum[DATA_W];
                v   = (x[15] == y[15]) && (o[15] != x[15]);
            end
            OP_SUB: begin
                // Carry out of SUB is the borrow.
                sum = {1'b0, x} - {1'b0, y};
                o   = sum[DATA_W-1:0];
                c   = sum[DATA_W];
                v   = (x[15] != y[15]) && (o[15] != x[15]);
            end
            OP_AND: o = x & y;
            OP_OR:  o = x | y;
            OP_XOR: o = x ^ y;
            OP_SHL: begin
                o = {x[14:0], 1'b0};
                c = x[15];
            end
            OP_SHR: begin
                o = {1'b0, x[15:1]};
                c = x[0];
            end
            default: o = '0;
        endcase
        flags         = '0;
        flags[FLAG_Z] = (o == '0);
        flags[FLAG_N] = o[15];
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/alu_bank_pipe_stage.sv
// One elastic register slice: loads when empty or when draining this cycle.
module alu_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Capture on accept, empty when the consumer takes the word and nothing replaces it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_bank_pipe.sv
// Bank of accumulator/flag contexts sharing one ALU, with an elastic result pipe.
module alu_bank_pipe
    import alu_bank_pkg::*;
#(
    parameter int NUM_ACC    = 4,
    parameter int PIPE_DEPTH = 1,
    localparam int CH_W      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [7:0]        in_op,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_y_acc,
    input  logic              in_wr_acc,
    input  logic              in_wr_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0] out_flags,
    output logic [CH_W-1:0]   out_ch
);

    logic [DATA_W-1:0] acc [NUM_ACC];
    logic [FLAG_W-1:0] flg [NUM_ACC];

    logic              accept;
    logic              in_range;
    logic [CH_W-1:0]   ch_idx;
    logic [DATA_W-1:0] acc_cur;
    logic [FLAG_W-1:0] flg_cur;
    logic [DATA_W-1:0] y_sel;
    logic [DATA_W-1:0] alu_o;
    logic [FLAG_W-1:0] alu_f;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] nxt_acc;
    logic [FLAG_W-1:0] nxt_flg;
    result_t           res;

    // Out-of-range channels read context 0 but never write or report it.
    assign in_range = int'(in_ch) < NUM_ACC;
    assign ch_idx   = in_range ? in_ch : '0;
    assign acc_cur  = acc[ch_idx];
    assign flg_cur  = flg[ch_idx];
    assign y_sel    = in_y_acc ? acc_cur : in_y;
    assign ld_val   = {8'h00, in_x[7:0]};
    assign accept   = in_valid && in_ready;

    alu_core u_alu (
        .op       (in_op),
        .x        (in_x),
        .y        (y_sel),
        .carry_in (flg_cur[FLAG_C]),
        .o        (alu_o),
        .flags    (alu_f)
    );

    // Next context state and the result word for the current command.
    always_comb begin
        nxt_acc = acc_cur;
        nxt_flg = flg_cur;
        res     = '0;
        res.ch[CH_W-1:0] = in_ch;
        if (in_range) begin
            case (in_mode)
                MODE_EXEC: begin
                    nxt_flg = alu_f;
                    if (in_wr_acc) nxt_acc = alu_o;
                    res.data  = alu_o;
                    res.flags = alu_f;
                end
                MODE_LOAD: begin
                    if (in_wr_acc)   nxt_acc = ld_val;
                    if (in_wr_flags) nxt_flg = in_x[11:8];
                    res.data  = ld_val;
                    res.flags = nxt_flg;
                end
                MODE_READ: begin
                    res.data  = acc_cur;
                    res.flags = flg_cur;
                end
                default: begin
                    nxt_acc = '0;
                    nxt_flg = '0;
                end
            endcase
        end
    end

    // Context bank: written only on an accepted, in-range command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc[i] <= '0;
                flg[i] <= '0;
            end
        end else if (accept && in_range) begin
            acc[ch_idx] <= nxt_acc;
            flg[ch_idx] <= nxt_flg;
        end
    end

    // Output pipeline: index 0 is the ALU side, index PIPE_DEPTH the consumer side.
    logic [PIPE_DEPTH:0] stg_valid;
    logic [PIPE_DEPTH:0] stg_ready;
    result_t             stg_data [PIPE_DEPTH+1];
    result_t             out_sel;

    assign stg_valid[0]          = in_valid;
    assign stg_data[0]           = res;
    assign stg_ready[PIPE_DEPTH] = out_ready;
    assign in_ready              = stg_ready[0];

    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
        alu_pipe_stage #(.W($bits(result_t))) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (stg_valid[i]),
            .in_ready  (stg_ready[i]),
            .in_data   (stg_data[i]),
            .out_valid (stg_valid[i+1]),
            .out_ready (stg_ready[i+1]),
            .out_data  (stg_data[i+1])
        );
    end

    if (PIPE_DEPTH == 0) begin : g_comb_out
        // Pass-through path still reports idle zeros while in reset.
        assign out_valid = stg_valid[0] && !reset;
        assign out_sel   = reset ? '0 : stg_data[0];
    end else begin : g_reg_out
        assign out_valid = stg_valid[PIPE_DEPTH];
        assign out_sel   = stg_data[PIPE_DEPTH];
    end

    assign out_data  = out_sel.data;
    assign out_flags = out_sel.flags;
    assign out_ch    = out_sel.ch[CH_W-1:0];

    // Upper channel bits beyond CH_W are always zero.
    logic unused_ch;
    assign unused_ch = ^out_sel.ch;

endmodule

// File: tb/tb_alu_bank_pipe.sv
// Randomised and directed bench for alu_bank_pipe against a queue-based model.
module tb_alu_bank_pipe;

    localparam int NA  = 5;   // non power of two so channels 5..7 are out of range
    localparam int PD  = 2;
    localparam int CHW = 3;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_ADC = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_XOR = 8'h05;
    localparam logic [7:0] OP_SHL = 8'h06;
    localparam logic [7:0] OP_SHR = 8'h07;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_mode = 2'd0;
    logic [CHW-1:0]  in_ch = '0;
    logic [7:0]      in_op = 8'h00;
    logic [15:0]     in_x = 16'h0000;
    logic [15:0]     in_y = 16'h0000;
    logic            in_y_acc = 1'b0;
    logic            in_wr_acc = 1'b0;
    logic            in_wr_flags = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [15:0]     out_data;
    logic [3:0]      out_flags;
    logic [CHW-1:0]  out_ch;

    alu_bank_pipe #(.NUM_ACC(NA), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_ch(in_ch), .in_op(in_op), .in_x(in_x), .in_y(in_y),
        .in_y_acc(in_y_acc), .in_wr_acc(in_wr_acc), .in_wr_flags(in_wr_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]    data;
        logic [3:0]     flags;
        logic [CHW-1:0] ch;
    } exp_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pops = 0;
    int          cyc_cnt = 0;
    exp_t        q[$];
    logic [15:0] ma [NA];
    logic [3:0]  mf [NA];
    logic [15:0] last_data = 16'h0;
    logic [3:0]  last_flags = 4'h0;
    logic [CHW-1:0] last_ch = '0;

    // Reference ALU from plain integer arithmetic; flags packed {V,C,N,Z}.
    function automatic logic [19:0] ref_alu(input logic [7:0] op, input logic [15:0] x,
                                            input logic [15:0] y, input logic cin);
        int ux, uy, sx, sy, r, sr;
        logic c, v;
        logic [15:0] o;
        ux = int'(x); uy = int'(y);
        sx = int'($signed(x)); sy = int'($signed(y));
        r = 0; sr = 0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin r = ux + uy; sr = sx + sy; c = r > 65535; v = sr > 32767 || sr < -32768; end
            OP_ADC: begin
                r = ux + uy + int'(cin); sr = sx + sy + int'(cin);
                c = r > 65535; v = sr > 32767 || sr < -32768;
            end
            OP_SUB: begin r = ux - uy; sr = sx - sy; c = ux < uy; v = sr > 32767 || sr < -32768; end
            OP_AND: r = int'(x & y);
            OP_OR:  r = int'(x | y);
            OP_XOR: r = int'(x ^ y);
            OP_SHL: begin r = ux * 2; c = ux >= 32768; end
            OP_SHR: begin r = ux / 2; c = (ux % 2) == 1; end
            default: r = 0;
        endcase
        o = r[15:0];
        return {o, v, c, o[15], o == 16'h0000};
    endfunction

    // Apply one accepted command to the model and queue its expected result.
    task automatic model_accept;
        exp_t e;
        logic [19:0] a;
        int c;
        c = int'(in_ch);
        e.ch = in_ch; e.data = 16'h0; e.flags = 4'h0;
        if (c < NA) begin
            case (in_mode)
                2'd0: begin
                    a = ref_alu(in_op, in_x, in_y_acc ? ma[c] : in_y, mf[c][2]);
                    mf[c] = a[3:0];
                    if (in_wr_acc) ma[c] = a[19:4];
                    e.data = a[19:4]; e.flags = a[3:0];
                end
                2'd1: begin
                    if (in_wr_acc) ma[c] = in_x & 16'h00FF;
                    if (in_wr_flags) mf[c] = in_x[11:8];
                    e.data = in_x & 16'h00FF; e.flags = mf[c];
                end
                2'd2: begin e.data = ma[c]; e.flags = mf[c]; end
                default: begin ma[c] = 16'h0; mf[c] = 4'h0; end
            endcase
        end
        q.push_back(e);
    endtask

    always @(posedge clk) cyc_cnt++;

    // Scoreboard: sampled mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            for (int i = 0; i < NA; i++) begin ma[i] = 16'h0; mf[i] = 4'h0; end
        end else begin
            if (out_valid && out_ready) begin
                exp_t e;
                n_checks++; pops++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output got data=%h flags=%h ch=%0d, none expected",
                             out_data, out_flags, out_ch);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.data || out_flags !== e.flags || out_ch !== e.ch) begin
                        n_fail++;
                        $display("FAIL result got data=%h flags=%h ch=%0d exp data=%h flags=%h ch=%0d",
                                 out_data, out_flags, out_ch, e.data, e.flags, e.ch);
                    end
                end
                last_data = out_data; last_flags = out_flags; last_ch = out_ch;
            end
            if (in_valid && in_ready) model_accept();
        end
    end

    // Present a command and hold it until accepted; returns just after the accept edge.
    task automatic drive(input logic [1:0] m, input logic [CHW-1:0] c, input logic [7:0] op,
                         input logic [15:0] x, input logic [15:0] y,
                         input logic ya, input logic wa, input logic wf);
        in_valid = 1'b1; in_mode = m; in_ch = c; in_op = op; in_x = x; in_y = y;
        in_y_acc = ya; in_wr_acc = wa; in_wr_flags = wf;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t > 50) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout got in_ready=0 exp 1 within 50 cycles");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 200 && q.size() != 0; t++) begin @(posedge clk); #1; end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d pending exp 0", q.size());
        end
    endtask

    task automatic rand_cmd;
        in_mode = 2'($urandom_range(0, 3));
        in_ch = ($urandom_range(0, 7) == 0) ? CHW'($urandom_range(NA, 7)) : CHW'($urandom_range(0, NA - 1));
        in_op = 8'($urandom_range(0, 9));
        in_x = 16'($urandom); in_y = 16'($urandom);
        in_y_acc = 1'($urandom); in_wr_acc = 1'($urandom); in_wr_flags = 1'($urandom);
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0000", out_data); end
        if (out_flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %h exp 0", out_flags); end
        if (out_ch !== '0) begin n_fail++; $display("FAIL reset_ch got %0d exp 0", out_ch); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_all;
        int lat;
        out_ready = 1'b1;
        for (int c = 0; c < NA; c++) begin
            drive(2'd2, CHW'(c), 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
            n_checks++;
            if (lat != PD) begin n_fail++; $display("FAIL latency ch%0d got %0d exp %0d", c, lat, PD); end
            drain();
            n_checks++;
            if (last_data !== 16'h0 || last_flags !== 4'h0) begin
                n_fail++; $display("FAIL read_after_reset ch%0d got %h/%h exp 0000/0", c, last_data, last_flags);
            end
        end
    endtask

    task automatic test_load;
        out_ready = 1'b1;
        drive(2'd1, 3'd2, 8'h00, 16'h0A5C, 16'h0, 1'b0, 1'b1, 1'b1);
        drive(2'd2, 3'd2, 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drain();
        n_checks++;
        if (last_data !== 16'h005C || last_flags !== 4'hA) begin
            n_fail++; $display("FAIL load_read got %h/%h exp 005c/a", last_data, last_flags);
        end
        for (int c = 0; c < NA; c++) begin
            if (c == 2) continue;
            drive(2'd2, CHW'(c), 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            drain();
            n_checks++;
            if (last_data !== 16'h0) begin n_fail++; $display("FAIL load_isolation ch%0d got %h exp 0000", c, last_data); end
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        out_ready = 1'b1;
        c0 = cyc_cnt;
        drive(2'd1, 3'd1, 8'h00, 16'h0010, 16'h0, 1'b0, 1'b1, 1'b0);
        drive(2'd0, 3'd1, OP_ADD, 16'h0005, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        drive(2'd2, 3'd1, 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (cyc_cnt - c0 != 3) begin n_fail++; $display("FAIL b2b_throughput got %0d cycles exp 3", cyc_cnt - c0); end
        drain();
        n_checks++;
        if (last_data !== 16'h0015) begin n_fail++; $display("FAIL b2b_dependency got %h exp 0015", last_data); end
    endtask

    task automatic test_clear_oor;
        out_ready = 1'b1;
        drive(2'd1, 3'd3, 8'h00, 16'h0FFF, 16'h0, 1'b0, 1'b1, 1'b1);
        drive(2'd3, 3'd3, 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(2'd2, 3'd3, 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drain();
        n_checks++;
        if (last_data !== 16'h0 || last_flags !== 4'h0) begin
            n_fail++; $display("FAIL clear got %h/%h exp 0000/0", last_data, last_flags);
        end
        drive(2'd1, 3'd0, 8'h00, 16'h0123, 16'h0, 1'b0, 1'b1, 1'b1);
        drive(2'd0, 3'd5, OP_ADD, 16'h1234, 16'h1111, 1'b1, 1'b1, 1'b0);
        drain();
        n_checks++;
        if (last_data !== 16'h0 || last_flags !== 4'h0 || last_ch !== 3'd5) begin
            n_fail++; $display("FAIL out_of_range got %h/%h ch%0d exp 0000/0 ch5", last_data, last_flags, last_ch);
        end
        drive(2'd2, 3'd0, 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drain();
        n_checks++;
        if (last_data !== 16'h0023 || last_flags !== 4'h1) begin
            n_fail++; $display("FAIL oor_no_side_effect got %h/%h exp 0023/1", last_data, last_flags);
        end
    endtask

    task automatic test_backpressure;
        logic [CHW-1:0] chs [6];
        logic [15:0] hd;
        logic [3:0] hf;
        logic [CHW-1:0] hc;
        logic a;
        int k, p0;
        out_ready = 1'b1;
        for (int c = 0; c < NA; c++)
            drive(2'd1, CHW'(c), 8'h00, 16'($urandom), 16'h0, 1'b0, 1'b1, 1'b1);
        drain();
        for (int i = 0; i < 6; i++) chs[i] = CHW'($urandom_range(0, NA - 1));
        out_ready = 1'b0; k = 0; hd = 16'h0; hf = 4'h0; hc = '0;
        for (int cy = 0; cy < 6; cy++) begin
            in_valid = 1'b1; in_mode = 2'd2; in_ch = chs[k];
            @(negedge clk);
            a = in_ready;
            if (cy == 2) begin hd = out_data; hf = out_flags; hc = out_ch; end
            if (cy > 2) begin
                n_checks++;
                if (out_data !== hd || out_flags !== hf || out_ch !== hc) begin
                    n_fail++; $display("FAIL stall_hold got %h/%h/%0d exp %h/%h/%0d", out_data, out_flags, out_ch, hd, hf, hc);
                end
            end
            @(posedge clk); #1;
            if (a) k++;
        end
        n_checks += 3;
        if (k != PD) begin n_fail++; $display("FAIL stall_accepts got %0d exp %0d", k, PD); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b exp 0", in_ready); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b exp 1", out_valid); end
        p0 = pops;
        out_ready = 1'b1;
        for (int cy = 0; cy < 6; cy++) begin
            if (k < 6) begin in_valid = 1'b1; in_ch = chs[k]; end else in_valid = 1'b0;
            @(negedge clk);
            a = in_valid && in_ready;
            @(posedge clk); #1;
            if (a) k++;
        end
        n_checks += 2;
        if (k != 6) begin n_fail++; $display("FAIL release_accepts got %0d exp 6", k); end
        if (pops - p0 != 6) begin n_fail++; $display("FAIL release_rate got %0d results in 6 cycles exp 6", pops - p0); end
        drain();
    endtask

    task automatic test_random;
        int acc_n, p0;
        logic a;
        acc_n = 0; p0 = pops;
        in_valid = 1'b0;
        for (int cy = 0; cy < 400; cy++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin rand_cmd(); in_valid = 1'b1; end
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            a = in_valid && in_ready;
            @(posedge clk); #1;
            if (a) begin in_valid = 1'b0; acc_n++; end
        end
        drain();
        n_checks++;
        if (pops - p0 != acc_n) begin n_fail++; $display("FAIL random_count got %0d results exp %0d", pops - p0, acc_n); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b1;
        for (int c = 0; c < NA; c++)
            drive(2'd1, CHW'(c), 8'h00, 16'h0F00 | 16'(c + 1), 16'h0, 1'b0, 1'b1, 1'b1);
        drain();
        out_ready = 1'b0;
        drive(2'd2, 3'd0, 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(2'd2, 3'd1, 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        // A LOAD presented during reset must not land.
        in_valid = 1'b1; in_mode = 2'd1; in_ch = 3'd2; in_x = 16'h0FAA; in_wr_acc = 1'b1; in_wr_flags = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b exp 0", out_valid); end
        if (out_data !== 16'h0) begin n_fail++; $display("FAIL async_data got %h exp 0000", out_data); end
        if (out_flags !== 4'h0 || out_ch !== '0) begin n_fail++; $display("FAIL async_flags_ch got %h/%0d exp 0/0", out_flags, out_ch); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready got %b exp 1", in_ready); end
        @(posedge clk); @(posedge clk); #1;
        in_valid = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < NA; c++) begin
            drive(2'd2, CHW'(c), 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            drain();
            n_checks++;
            if (last_data !== 16'h0 || last_flags !== 4'h0) begin
                n_fail++; $display("FAIL post_reset_read ch%0d got %h/%h exp 0000/0", c, last_data, last_flags);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_load();
        test_back_to_back();
        test_clear_oor();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_bank_pipe.md
Name: alu_bank_pipe

Overview:
- Parametrised successor of the single-accumulator synchronous ALU wrapper.
- Holds a bank of NUM_ACC accumulator/flag contexts around one shared combinational ALU instance.
- Takes commands through a valid/ready handshake and returns results through an elastic output pipeline of PIPE_DEPTH stages.
- Sits between the CPU decode/sequencer and the register writeback path, so several register contexts share one ALU.

Parameters:
- NUM_ACC, 4, number of accumulator/flag contexts; 1..16.
- PIPE_DEPTH, 1, number of output register stages; 0..3; 0 = combinational result path.
- CH_W, $clog2(NUM_ACC) minimum 1, channel index width (derived localparam).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- in_mode  in  2  0 EXEC, 1 LOAD, 2 READ, 3 CLEAR
- in_ch  in  CH_W  target context
- in_op  in  8  ALU opcode (EXEC only)
- in_x  in  16  first operand / load data
- in_y  in  16  second operand
- in_y_acc  in  1  1 = second operand is A[in_ch] instead of in_y
- in_wr_acc  in  1  write result to A[in_ch]
- in_wr_flags  in  1  LOAD only: write F[in_ch]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  16  result
- out_flags  out  4  flags after the command
- out_ch  out  CH_W  context the result belongs to

Behaviour:
- Architectural state: A[NUM_ACC] 16-bit, F[NUM_ACC] 4-bit.
- State updates on the accept edge only (in_valid && in_ready). Result enters the output pipeline on the same edge.
- EXEC:
  - ALU(in_op, in_x, Y', F[in_ch]) where Y' = in_y_acc ? A[in_ch] : in_y.
  - F[in_ch] <= ALU flag out, always.
  - A[in_ch] <= O if in_wr_acc.
  - Result = O with the new flags.
- LOAD:
  - A[in_ch] <= {8'h00, in_x[7:0]} if in_wr_acc.
  - F[in_ch] <= in_x[11:8] if in_wr_flags.
  - Result = {8'h00, in_x[7:0]}; flags = the F value after the write.
- READ: no state change; result = A[in_ch], flags = F[in_ch].
- CLEAR: A[in_ch] <= 0, F[in_ch] <= 0; result 0, flags 0.
- in_ch >= NUM_ACC: command is accepted, no state change, result 16'h0000, flags 0.
- Back-to-back commands on the same channel: the second reads the state written by the first. No stall is needed because state reads are combinational from registers.
- Output pipeline:
  - PIPE_DEPTH stages, each a registered {valid, data, flags, ch}.
  - A stage loads when it is empty or when its downstream consumer accepts in the same cycle.
  - in_ready = first stage empty OR first stage advancing. Full-throughput back-to-back operation is required; no bubble is inserted when out_ready is held high.
  - Latency: PIPE_DEPTH cycles from accept to out_valid.
  - While out_valid && !out_ready, out_data/out_flags/out_ch hold stable.
- PIPE_DEPTH=0:
  - out_valid = in_valid; in_ready = out_ready; outputs are combinational.
  - State still updates only on accept.
- Reset (asynchronous, any time including mid-transfer): all A, F = 0; all stage valids = 0; out_valid = 0; out_data = 0; out_flags = 0; out_ch = 0. in_ready = 1 when PIPE_DEPTH > 0.
- Results in flight at reset are discarded. No command is accepted while reset is asserted.

Decomposition:
- Package alu_bank_pkg:
  - mode constants MODE_EXEC/LOAD/READ/CLEAR (2 bits)
  - DATA_W=16, FLAG_W=4
  - result-stage struct {data, flags, ch}
- ALU opcodes stay in the existing ALU definitions.
- Sub-module alu_pipe_stage: one elastic register slice (valid/ready, payload width parameter), instantiated PIPE_DEPTH times in a generate loop.
- The existing combinational ALU is instantiated once.

Test Plan:
- Reset, then READ on each channel 0..3 -> results 0, flags 0. With PIPE_DEPTH=1, each result appears exactly 1 cycle after accept.
- LOAD ch2, in_x=16'h0A5C, wr_acc=1, wr_flags=1; then READ ch2 -> result 16'h005C, flags 4'hA. Other channels stay 0.
- LOAD ch1 A=8'h10; EXEC ADD ch1, in_x=16'h0005, in_y_acc=1, wr_acc=1; next cycle READ ch1 -> 16'h0015. Checks the same-channel back-to-back dependency with no bubble.
- PIPE_DEPTH=2: issue 6 READs while out_ready=0 -> in_ready drops after 2 accepts and outputs hold stable. Release out_ready -> results emerge in order at one per cycle with correct out_ch.
- Assert reset asynchronously (mid-cycle) with 2 results in flight -> out_valid=0 immediately and all A/F=0. After release, READ returns 0.
- CLEAR ch3 after LOAD ch3 16'h0FFF; command to in_ch=5 with NUM_ACC=4 -> ch3 reads 0/0; out-of-range command returns 0 and changes no state.
